rf_wr_arbiter: RTL and testbench

Write-port controller for the 32x32 two-read/one-write register file (rf).
- After reset, and on demand, it sweeps every register to a known value.
- In normal operation it shares the single write port (w, wn, wd) between two requesters using round-robin valid/ready handshakes.
- It sits directly in front of rf's write inputs. Read ports are not touched.

---
 rtl/rf_pkg.sv | 18 +
 rtl/rr_arb2.sv | 36 +++
 rtl/rf_wr_arbiter.sv | 118 +++++++++++
 tb/tb_rf_wr_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared constants and types for the register-file write-port controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rf_pkg;

   localparam int AW   = 5;    // register-number width, matches rf wn
   localparam int DW   = 32;   // data width, matches rf wd
   localparam int NREG = 32;   // registers covered by one init sweep

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Identifies one of the two write requesters.
   typedef logic req_id_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant logic; the pointer is owned by the caller.
// Latency: purely combinational, grant in the same cycle as valid.
// Backpressure: en=0 withholds both grants; at most one grant is ever high.
//
// Ports:
//   en          grants allowed this cycle
//   valid0/1    requester has a pending write
//   last_grant  requester granted most recently (loser of the next tie)
//   gnt0/1      one-hot (or zero) grant
module rr_arb2
   import rf_pkg::*;
(
   input  logic    en,
   input  logic    valid0,
   input  logic    valid1,
   input  req_id_t last_grant,
   output logic    gnt0,
   output logic    gnt1
);

   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (en) begin
         if (valid0 && valid1) begin
            // Tie: the requester that did not win last time goes first.
            gnt0 = (last_grant == 1'b1);
            gnt1 = (last_grant == 1'b0);
         end else begin
            gnt0 = valid0;
            gnt1 = valid1;
         end
      end
   end

endmodule

// File: rtl/rf_wr_arbiter.sv
// Write-port controller for the 32x32 rf: init sweep, then round-robin sharing.
// Latency: write accepted in cycle N appears on rf_w/rf_wn/rf_wd in cycle N+1.
// Backpressure: readies are 0 during a sweep and in the cycle init_start is high.
//
// Ports:
//   clk, rst_n             clock (rf samples on the same edge), async active-low reset
//   req0_* / req1_*        valid/ready write requests (wn = register, wd = data)
//   init_start             start a fresh sweep of all registers to INIT_VAL
//   busy                   sweep in progress
//   rf_w, rf_wn, rf_wd     registered drive of rf's write port
//   last_grant             requester most recently granted
module rf_wr_arbiter
   import rf_pkg::*;
#(
   parameter int                       NREG     = rf_pkg::NREG,
   parameter int                       AW       = rf_pkg::AW,
   parameter int                       DW       = rf_pkg::DW,
   parameter logic [DW-1:0]            INIT_VAL = '0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req0_valid,
   input  logic [AW-1:0] req0_wn,
   input  logic [DW-1:0] req0_wd,
   output logic          req0_ready,
   input  logic          req1_valid,
   input  logic [AW-1:0] req1_wn,
   input  logic [DW-1:0] req1_wd,
   output logic          req1_ready,
   input  logic          init_start,
   output logic          busy,
   output logic          rf_w,
   output logic [AW-1:0] rf_wn,
   output logic [DW-1:0] rf_wd,
   output logic          last_grant
);

   // One extra counter bit so the final index compares cleanly for NREG=2**AW.
   localparam logic [AW:0] LAST_IDX = (AW+1)'(NREG - 1);

   state_t        state;
   logic [AW:0]   cnt;
   logic          arb_en;
   logic          gnt0;
   logic          gnt1;

   // init_start blocks grants in its own cycle so no write is lost across the switch.
   assign arb_en = (state == RUN) && !init_start;

   rr_arb2 u_arb (
      .en         (arb_en),
      .valid0     (req0_valid),
      .valid1     (req1_valid),
      .last_grant (last_grant),
      .gnt0       (gnt0),
      .gnt1       (gnt1)
   );

   assign req0_ready = gnt0;
   assign req1_ready = gnt1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= INIT;
         cnt        <= '0;
         busy       <= 1'b1;
         rf_w       <= 1'b0;
         rf_wn      <= '0;
         rf_wd      <= '0;
         last_grant <= 1'b1;
      end else begin
         case (state)
            INIT: begin
               rf_w  <= 1'b1;
               rf_wn <= cnt[AW-1:0];
               rf_wd <= INIT_VAL;
               if (init_start) begin
                  cnt <= '0;
               end else if (cnt == LAST_IDX) begin
                  cnt   <= '0;
                  state <= RUN;
                  busy  <= 1'b0;
               end else begin
                  cnt <= cnt + (AW+1)'(1);
               end
            end
            RUN: begin
               if (init_start) begin
                  state <= INIT;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  rf_w  <= 1'b0;
               end else if (gnt0) begin
                  rf_w       <= 1'b1;
                  rf_wn      <= req0_wn;
                  rf_wd      <= req0_wd;
                  last_grant <= 1'b0;
               end else if (gnt1) begin
                  rf_w       <= 1'b1;
                  rf_wn      <= req1_wn;
                  rf_wd      <= req1_wd;
                  last_grant <= 1'b1;
               end else begin
                  // Idle: address/data hold, only the strobe drops.
                  rf_w <= 1'b0;
               end
            end
            default: begin
               state <= INIT;
               cnt   <= '0;
               busy  <= 1'b1;
               rf_w  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Bench for rf_wr_arbiter: cycle model plus directed scenarios.
// Latency: n/a.
// Backpressure: n/a.
module tb_rf_wr_arbiter;

   localparam int AW   = 5;
   localparam int DW   = 32;
   localparam int NREG = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req0_valid = 1'b0;
   logic [AW-1:0] req0_wn = '0;
   logic [DW-1:0] req0_wd = '0;
   logic          req0_ready;
   logic          req1_valid = 1'b0;
   logic [AW-1:0] req1_wn = '0;
   logic [DW-1:0] req1_wd = '0;
   logic          req1_ready;
   logic          init_start = 1'b0;
   logic          busy;
   logic          rf_w;
   logic [AW-1:0] rf_wn;
   logic [DW-1:0] rf_wd;
   logic          last_grant;

   always #5 clk = ~clk;

   rf_wr_arbiter #(.NREG(NREG), .AW(AW), .DW(DW), .INIT_VAL('0)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_wn    (req0_wn),
      .req0_wd    (req0_wd),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_wn    (req1_wn),
      .req1_wd    (req1_wd),
      .req1_ready (req1_ready),
      .init_start (init_start),
      .busy       (busy),
      .rf_w       (rf_w),
      .rf_wn      (rf_wn),
      .rf_wd      (rf_wd),
      .last_grant (last_grant)
   );

   // Stand-in register file fed by the DUT's write port.
   logic [DW-1:0] mem [NREG];
   always @(posedge clk) if (rf_w) mem[rf_wn] <= rf_wd;

   int n_cmp  = 0;
   int n_fail = 0;
   int cyc    = 0;
   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit          m_init;
   int          m_cnt;
   bit          m_last;
   bit          e_w;
   int          e_wn;
   logic [31:0] e_wd;

   function automatic bit want0();
      return !m_init && !init_start && req0_valid && (!req1_valid || m_last);
   endfunction
   function automatic bit want1();
      return !m_init && !init_start && req1_valid && (!req0_valid || !m_last);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_init = 1; m_cnt = 0; m_last = 1; e_w = 0; e_wn = 0; e_wd = 0;
      end else begin
         bit g0, g1;
         g0 = want0();
         g1 = want1();
         if (m_init) begin
            e_w = 1; e_wn = m_cnt; e_wd = 0;
            if (init_start) m_cnt = 0;
            else if (m_cnt == NREG - 1) begin m_init = 0; m_cnt = 0; end
            else m_cnt++;
         end else if (init_start) begin
            m_init = 1; m_cnt = 0; e_w = 0;
         end else if (g0) begin
            e_w = 1; e_wn = int'(req0_wn); e_wd = req0_wd; m_last = 0;
         end else if (g1) begin
            e_w = 1; e_wn = int'(req1_wn); e_wd = req1_wd; m_last = 1;
         end else begin
            e_w = 0;
         end
      end
   end

   always @(negedge clk) begin
      chk("busy",  32'(busy),       32'(m_init));
      chk("rdy0",  32'(req0_ready), 32'(want0()));
      chk("rdy1",  32'(req1_ready), 32'(want1()));
      chk("rf_w",  32'(rf_w),       32'(e_w));
      chk("rf_wn", 32'(rf_wn),      32'(e_wn));
      chk("rf_wd", rf_wd,           e_wd);
      chk("lastg", 32'(last_grant), 32'(m_last));
   end

   // ---------------- write / grant logs ----------------
   logic [31:0] lg_wn[$];
   logic [31:0] lg_wd[$];
   int          lg_cyc[$];
   int          gl[$];

   always @(negedge clk) begin
      if (rf_w) begin
         lg_wn.push_back(32'(rf_wn));
         lg_wd.push_back(rf_wd);
         lg_cyc.push_back(cyc);
      end
      if (req0_ready) gl.push_back(0);
      if (req1_ready) gl.push_back(1);
   end

   task automatic clear_logs();
      lg_wn.delete(); lg_wd.delete(); lg_cyc.delete(); gl.delete();
   endtask

   task automatic wait_idle(input string nm, input int max_cyc);
      int k;
      for (k = 0; k < max_cyc; k++) begin
         @(negedge clk);
         if (!busy) break;
      end
      n_cmp++;
      if (k == max_cyc) begin
         n_fail++;
         $display("FAIL %s: busy still high after %0d cycles, expected low", nm, max_cyc);
      end
      @(negedge clk);
   endtask

   // Checks a log segment of NREG init writes starting at index base.
   task automatic chk_sweep(input string nm, input int base);
      for (int i = 0; i < NREG; i++) begin
         if (base + i < lg_wn.size()) begin
            chk({nm, "_wn"},  lg_wn[base+i], 32'(i));
            chk({nm, "_wd"},  lg_wd[base+i], 32'h0);
            chk({nm, "_gap"}, 32'(lg_cyc[base+i] - lg_cyc[base]), 32'(i));
         end
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   // ---------------- directed scenarios ----------------
   initial begin
      int i0, i1, k;
      bit s0, s1;

      // Reset values
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_rf_w",  32'(rf_w), 32'h0);
      chk("rst_busy",  32'(busy), 32'h1);
      chk("rst_lastg", 32'(last_grant), 32'h1);
      chk("rst_rdy",   32'({req0_ready, req1_ready}), 32'h0);
      clear_logs();
      #1 rst_n = 1'b1;

      // Power-up sweep
      wait_idle("sweep_done", 60);
      chk("sweep_cnt", 32'(lg_wn.size()), 32'd32);
      chk_sweep("sweep", 0);
      @(negedge clk);
      chk("rd7",  mem[7],  32'h0);
      chk("rd31", mem[31], 32'h0);

      // Both requesters continuously valid: alternate 0,1,0,1...
      @(posedge clk); #1;
      clear_logs();
      i0 = 0; i1 = 0;
      for (k = 0; k < 20 && (i0 < 4 || i1 < 4); k++) begin
         req0_valid = (i0 < 4); req0_wn = AW'(i0);      req0_wd = 32'(i0 * i0);
         req1_valid = (i1 < 4); req1_wn = AW'(16 + i1); req1_wd = 32'(100 + i1);
         @(negedge clk);
         s0 = req0_ready; s1 = req1_ready;
         @(posedge clk); #1;
         if (s0) i0++;
         if (s1) i1++;
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("cont_grants", 32'(gl.size()), 32'd8);
      chk("cont_writes", 32'(lg_wn.size()), 32'd8);
      for (int j = 0; j < 8; j++) begin
         if (j < gl.size()) chk("cont_order", 32'(gl[j]), 32'(j % 2));
         if (j < lg_wn.size()) begin
            chk("cont_wn",  lg_wn[j], (j % 2 == 0) ? 32'(j/2) : 32'(16 + j/2));
            chk("cont_wd",  lg_wd[j], (j % 2 == 0) ? 32'((j/2) * (j/2)) : 32'(100 + j/2));
            chk("cont_gap", 32'(lg_cyc[j] - lg_cyc[0]), 32'(j));
         end
      end

      // req0 alone, one request
      @(posedge clk); #1;
      req0_valid = 1'b1; req0_wn = 5'd5; req0_wd = 32'd25;
      @(negedge clk);
      chk("r0_rdy", 32'(req0_ready), 32'h1);
      @(posedge clk); #1;
      req0_valid = 1'b0;
      @(negedge clk);
      chk("r0_w",  32'(rf_w),  32'h1);
      chk("r0_wn", 32'(rf_wn), 32'd5);
      chk("r0_wd", rf_wd,      32'd25);
      @(negedge clk);
      chk("rd5", mem[5], 32'd25);

      // req1 back-to-back, 8 writes
      @(posedge clk); #1;
      clear_logs();
      i1 = 0;
      for (k = 0; k < 20 && i1 < 8; k++) begin
         req1_valid = 1'b1; req1_wn = AW'(20 + i1); req1_wd = 32'hA0 + 32'(i1);
         @(negedge clk);
         s1 = req1_ready;
         @(posedge clk); #1;
         if (s1) i1++;
      end
      req1_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("r1_writes", 32'(lg_wn.size()), 32'd8);
      for (int j = 0; j < 8; j++) begin
         if (j < lg_wn.size()) begin
            chk("r1_wn",  lg_wn[j], 32'(20 + j));
            chk("r1_wd",  lg_wd[j], 32'hA0 + 32'(j));
            chk("r1_gap", 32'(lg_cyc[j] - lg_cyc[0]), 32'(j));
         end
      end
      chk("r1_lastg", 32'(last_grant), 32'h1);

      // init_start while both requesters valid
      @(posedge clk); #1;
      clear_logs();
      req0_valid = 1'b1; req0_wn = 5'd3; req0_wd = 32'd33;
      req1_valid = 1'b1; req1_wn = 5'd4; req1_wd = 32'd44;
      init_start = 1'b1;
      @(negedge clk);
      chk("is_rdy0", 32'(req0_ready), 32'h0);
      chk("is_rdy1", 32'(req1_ready), 32'h0);
      @(posedge clk); #1;
      init_start = 1'b0;
      @(negedge clk);
      chk("is_busy", 32'(busy), 32'h1);
      for (k = 0; k < 80 && (req0_valid || req1_valid); k++) begin
         @(negedge clk);
         s0 = req0_ready; s1 = req1_ready;
         @(posedge clk); #1;
         if (s0) req0_valid = 1'b0;
         if (s1) req1_valid = 1'b0;
      end
      chk("is_drained", 32'({req0_valid, req1_valid}), 32'h0);
      repeat (2) @(negedge clk);
      chk("is_writes", 32'(lg_wn.size()), 32'd34);
      chk_sweep("is_sweep", 0);
      if (lg_wn.size() >= 34) begin
         chk("is_post_wn0", lg_wn[32], 32'd3);
         chk("is_post_wd0", lg_wd[32], 32'd33);
         chk("is_post_wn1", lg_wn[33], 32'd4);
         chk("is_post_wd1", lg_wd[33], 32'd44);
      end
      chk("rd3",  mem[3], 32'd33);
      chk("rd4",  mem[4], 32'd44);
      chk("rd5b", mem[5], 32'h0);

      // Reset asserted mid-sweep at rf_wn=10
      @(posedge clk); #1;
      init_start = 1'b1;
      @(posedge clk); #1;
      init_start = 1'b0;
      for (k = 0; k < 60; k++) begin
         @(negedge clk);
         if (rf_w && rf_wn == 5'd10) break;
      end
      chk("mr_found", 32'(k < 60), 32'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("mr_rf_w",  32'(rf_w),  32'h0);
      chk("mr_rf_wn", 32'(rf_wn), 32'h0);
      chk("mr_busy",  32'(busy),  32'h1);
      repeat (2) @(negedge clk);
      clear_logs();
      #1 rst_n = 1'b1;
      wait_idle("mr_done", 60);
      chk("mr_writes", 32'(lg_wn.size()), 32'd32);
      chk_sweep("mr_sweep", 0);
      @(negedge clk);
      for (int j = 0; j < NREG; j++) chk("mr_rd", mem[j], 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
